// File: rtl/median_feeder_pkg.sv
// Shared types for the median feeder: FSM state encoding and window indexing.
// The optional watchdog is enabled with the MEDIAN_FEEDER_WDOG_EN macro.
package median_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        BURST  = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int WIN_N = 9;

    typedef logic [3:0] win_idx_t;

    localparam win_idx_t LAST_IDX = win_idx_t'(WIN_N - 1);

endpackage

// File: rtl/median_feeder_if.sv
// Bundle of the pixel input stream, the median-engine handshake and the filtered output.
// The master side is the feeder, the slave side is its environment.
interface median_feeder_if #(
    parameter int W = 8
);
    // Pixel input: a pixel is transferred on a rising CLK edge where PIX_VAL and PIX_RDY
    // are both high; while PIX_RDY is low the source holds PIX_IN/PIX_VAL unchanged.
    // Median engine: MED_DSI is high for 9 back-to-back samples, MED_DSO is a one-cycle result strobe.
    logic [W-1:0] PIX_IN;
    logic         PIX_VAL;
    logic         PIX_RDY;
    logic [W-1:0] MED_DI;
    logic         MED_DSI;
    logic [W-1:0] MED_DO;
    logic         MED_DSO;
    logic [W-1:0] PIX_OUT;
    logic         PIX_OVAL;
    logic         ERR;

    modport master (
        input  PIX_IN, PIX_VAL, MED_DO, MED_DSO,
        output PIX_RDY, MED_DI, MED_DSI, PIX_OUT, PIX_OVAL, ERR
    );

    modport slave (
        output PIX_IN, PIX_VAL, MED_DO, MED_DSO,
        input  PIX_RDY, MED_DI, MED_DSI, PIX_OUT, PIX_OVAL, ERR
    );

endinterface

// File: rtl/median_feeder_line_buffer.sv
// Single-port line memory: the old word at addr is visible combinationally while the
// new word is written on the same edge (read-before-write). Contents are not reset.
module line_buffer #(
    parameter int W     = 8,
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/median_feeder.sv
// 3x3 window former feeding a 9-sample median engine and forwarding its result.
// Define MEDIAN_FEEDER_WDOG_EN to enable the WAIT-state watchdog and sticky ERR.
module median_feeder
    import median_pkg::*;
#(
    parameter int W       = 8,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int TIMEOUT = 64
) (
    input  logic           CLK,
    input  logic           nRST,
    median_feeder_if.master bus,
    output state_t         dbg_state
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    state_t         state;
    state_t         state_nx;
    win_idx_t       k;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [W-1:0]   win [WIN_N];
    logic [W-1:0]   line0_q;
    logic [W-1:0]   line1_q;
    logic [W-1:0]   pix_out_q;
    logic           oval_q;
    logic           accept;
    logic           emit;
    logic           timeout;

    assign accept = (state == ACCEPT) && bus.PIX_VAL;
    // Only interior positions have a window made purely of this frame's lines.
    assign emit   = accept && (x >= XW'(2)) && (y >= YW'(2));

    // line0 holds the previous line, line1 the one before it.
    line_buffer #(.W(W), .DEPTH(IMG_W)) u_line0 (
        .CLK   (CLK),
        .we    (accept),
        .addr  (x),
        .wdata (bus.PIX_IN),
        .rdata (line0_q)
    );

    line_buffer #(.W(W), .DEPTH(IMG_W)) u_line1 (
        .CLK   (CLK),
        .we    (accept),
        .addr  (x),
        .wdata (line0_q),
        .rdata (line1_q)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ACCEPT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACCEPT:  if (emit) state_nx = BURST;
            BURST:   if (k == LAST_IDX) state_nx = WAIT;
            WAIT:    if (bus.MED_DSO || timeout) state_nx = ACCEPT;
            default: state_nx = ACCEPT;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            k <= '0;
        end else if (state == BURST) begin
            k <= k + win_idx_t'(1);
        end else begin
            k <= '0;
        end
    end

    // Window is row-major with column 2 the newest; row 0 comes from line1 (oldest line).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < WIN_N; i++) begin
                win[i] <= '0;
            end
            x         <= '0;
            y         <= '0;
            pix_out_q <= '0;
            oval_q    <= 1'b0;
        end else begin
            oval_q <= 1'b0;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r*3]   <= win[r*3+1];
                    win[r*3+1] <= win[r*3+2];
                end
                win[2] <= line1_q;
                win[5] <= line0_q;
                win[8] <= bus.PIX_IN;
                if (x == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= (y == YW'(IMG_H - 1)) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
            if ((state == WAIT) && bus.MED_DSO) begin
                pix_out_q <= bus.MED_DO;
                oval_q    <= 1'b1;
            end
        end
    end

`ifdef MEDIAN_FEEDER_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wcnt;
    logic          err_q;

    // A result arriving on the last allowed cycle still wins over the timeout.
    assign timeout = (state == WAIT) && !bus.MED_DSO && (wcnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + CW'(1) : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ERR = err_q;
`else
    assign timeout = 1'b0;
    assign bus.ERR = 1'b0;
`endif

    assign bus.PIX_RDY  = (state == ACCEPT);
    assign bus.MED_DSI  = (state == BURST);
    assign bus.MED_DI   = (state == BURST) ? win[k] : '0;
    assign bus.PIX_OUT  = pix_out_q;
    assign bus.PIX_OVAL = oval_q;
    assign dbg_state    = state;

endmodule
